mmio_controller: RTL

//  Sequences CPU loads and stores to the MMIO segment at 0xFFFF0000..0xFFFF000F.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_timeout_cnt.sv | 30 +++
 rtl/mmio_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MEM-stage MMIO controller.
// Device i occupies one 32-bit word at base + 4*i.
package mmio_pkg;

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} mmio_state_t;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

   localparam int DEV_UART  = 0;
   localparam int DEV_TIMER = 1;
   localparam int DEV_GPIO  = 2;
   localparam int DEV_LED   = 3;

   // True when addr falls inside [base, base + 4*ndev); the subtraction keeps the top-of-memory segment from wrapping.
   function automatic logic mmio_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned ndev);
      logic [31:0] offset;
      offset = addr - base;
      return (addr >= base) && (offset < (ndev << 2));
   endfunction

endpackage

// File: rtl/mmio_timeout_cnt.sv
// Clear/enable cycle counter that flags when a request has waited TIMEOUT cycles.
// expired is combinational so the FSM can act on it within the same REQ cycle.
module mmio_timeout_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_controller.sv
// MEM-stage MMIO sequencer: plain accesses go to data memory, MMIO accesses
// run a req/ack handshake with a device while the pipeline is stalled.
module mmio_controller
   import mmio_pkg::*;
#(
   parameter int          NUM_DEV   = 4,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   parameter int          TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 memread,
   input  logic                 memwrite,
   input  logic [31:0]          addr,
   input  logic [31:0]          writedata,
   output logic                 we_mem,
   output logic                 stall,
   output logic [31:0]          readdata,
   output logic                 rdata_valid,
   output logic                 bus_err,
   output logic [NUM_DEV-1:0]   dev_req,
   output logic                 dev_we,
   output logic [31:0]          dev_wdata,
   input  logic [NUM_DEV-1:0]   dev_ack,
   input  logic [NUM_DEV*32-1:0] dev_rdata
);

   localparam int IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

   mmio_state_t   state;
   logic [IW-1:0] idx;
   logic          hit;
   logic          aligned;
   logic          start;
   logic          expired;
   logic          ack_sel;

   assign hit     = (memread | memwrite) & mmio_hit(addr, MMIO_BASE, NUM_DEV);
   assign aligned = (addr[1:0] == 2'b00);
   assign start   = (state == IDLE) & hit & aligned;
   assign stall   = start | (state == REQ);
   assign we_mem  = memwrite & ~hit;
   // Only the line of the device being served can complete the transaction.
   assign ack_sel = dev_ack[idx];

   mmio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (start),
      .enable  (state == REQ),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         idx         <= '0;
         dev_req     <= '0;
         dev_we      <= 1'b0;
         dev_wdata   <= '0;
         readdata    <= '0;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (hit && !aligned) begin
                  bus_err <= 1'b1;
                  state   <= ERR;
               end else if (hit) begin
                  idx       <= addr[2 +: IW];
                  dev_we    <= memwrite;
                  dev_wdata <= writedata;
                  dev_req   <= NUM_DEV'(1) << addr[2 +: IW];
                  state     <= REQ;
               end
            end
            REQ: begin
               // An ack on the timeout cycle still counts as success.
               if (ack_sel) begin
                  dev_req <= '0;
                  if (!dev_we) begin
                     readdata    <= dev_rdata[32*idx +: 32];
                     rdata_valid <= 1'b1;
                  end
                  state <= DONE;
               end else if (expired) begin
                  dev_req <= '0;
                  bus_err <= 1'b1;
                  state   <= ERR;
               end
            end
            DONE, ERR: state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule
